// File: rtl/rx_packet_reader.sv
`default_nettype none
// ============================================================================
// Module      : rx_packet_reader
// Description : Read-side packet engine for the receive sample FIFO. Waits for
//               a synchronized packet-available flag and host readiness, reads
//               exactly one packet of words, forwards them with start/end
//               framing, flags data-tag words and keeps packet/tag statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_packet_reader #(
  parameter int          PKT_WORDS  = 256,
  parameter logic [15:0] TAG_WORD   = 16'h4000,
  parameter int          RD_LATENCY = 1,
  parameter int          HOLDOFF    = 4
) (
  input  logic        rd_clk,
  input  logic        rd_reset,
  input  logic        packet_rdy,
  input  logic [15:0] fifo_dout,
  input  logic        fx2_ready,
  input  logic        clear_status,
  output logic        rd_req,
  output logic [15:0] out_data,
  output logic        out_valid,
  output logic        pkt_start,
  output logic        pkt_end,
  output logic        tag_seen,
  output logic [15:0] tag_count,
  output logic [15:0] pkt_count,
  output logic        busy
);

  localparam int       c_WAIT_MAX = (HOLDOFF > RD_LATENCY) ? HOLDOFF : RD_LATENCY;
  localparam int       c_WAIT_W   = $clog2(c_WAIT_MAX + 1);
  localparam logic [8:0] c_LAST   = 9'(PKT_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t                r_state;
  logic                  r_prdy_m;
  logic                  r_prdy_s;
  logic [8:0]            r_word_cnt;
  logic [8:0]            r_ret_cnt;
  logic [c_WAIT_W-1:0]   r_wait;
  logic [RD_LATENCY-1:0] r_vld_sr;
  logic                  w_vld_nxt;

  // Two-flop synchronizer for the write-domain packet-available flag
  always_ff @(posedge rd_clk or posedge rd_reset) begin
    if (rd_reset) begin
      r_prdy_m <= 1'b0;
      r_prdy_s <= 1'b0;
    end else begin
      r_prdy_m <= packet_rdy;
      r_prdy_s <= r_prdy_m;
    end
  end

  // Packet sequencer: grant, burst of read requests, drain, hold-off
  always_ff @(posedge rd_clk or posedge rd_reset) begin
    if (rd_reset) begin
      r_state    <= S_IDLE;
      r_word_cnt <= 9'd0;
      r_wait     <= '0;
      rd_req     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_prdy_s && fx2_ready) r_state <= S_ARM;
        end
        S_ARM: begin
          r_word_cnt <= 9'd0;
          rd_req     <= 1'b1;
          r_state    <= S_READ;
        end
        S_READ: begin
          r_word_cnt <= r_word_cnt + 9'd1;
          if (r_word_cnt == c_LAST) begin
            rd_req  <= 1'b0;
            r_wait  <= '0;
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (r_wait == c_WAIT_W'(RD_LATENCY - 1)) begin
            r_wait  <= '0;
            r_state <= S_HOLD;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_HOLD: begin
          if (r_wait == c_WAIT_W'(HOLDOFF - 1)) begin
            r_state <= S_IDLE;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        default: begin
          rd_req  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);

  // w_vld_nxt is the value out_valid takes at the coming edge; fifo_dout is
  // captured on that same edge so out_data lines up with out_valid.
  if (RD_LATENCY == 1) begin : g_lat_one
    assign w_vld_nxt = rd_req;
  end else begin : g_lat_multi
    assign w_vld_nxt = r_vld_sr[RD_LATENCY-2];
  end

  // Request delay line that mirrors the FIFO read latency
  always_ff @(posedge rd_clk or posedge rd_reset) begin
    if (rd_reset) begin
      r_vld_sr <= '0;
    end else begin
      r_vld_sr[0] <= rd_req;
      for (int i = 1; i < RD_LATENCY; i++) r_vld_sr[i] <= r_vld_sr[i-1];
    end
  end

  assign out_valid = r_vld_sr[RD_LATENCY-1];

  // Return-side capture, framing from the return word counter, tag detect
  always_ff @(posedge rd_clk or posedge rd_reset) begin
    if (rd_reset) begin
      out_data  <= 16'd0;
      pkt_start <= 1'b0;
      pkt_end   <= 1'b0;
      tag_seen  <= 1'b0;
      r_ret_cnt <= 9'd0;
    end else if (w_vld_nxt) begin
      out_data  <= fifo_dout;
      pkt_start <= (r_ret_cnt == 9'd0);
      pkt_end   <= (r_ret_cnt == c_LAST);
      tag_seen  <= (fifo_dout == TAG_WORD);
      r_ret_cnt <= (r_ret_cnt == c_LAST) ? 9'd0 : r_ret_cnt + 9'd1;
    end else begin
      pkt_start <= 1'b0;
      pkt_end   <= 1'b0;
      tag_seen  <= 1'b0;
    end
  end

  // Status counters; a clear request overrides any same-cycle increment
  always_ff @(posedge rd_clk or posedge rd_reset) begin
    if (rd_reset) begin
      tag_count <= 16'd0;
      pkt_count <= 16'd0;
    end else if (clear_status) begin
      tag_count <= 16'd0;
      pkt_count <= 16'd0;
    end else begin
      if (tag_seen && (tag_count != 16'hFFFF)) tag_count <= tag_count + 16'd1;
      if (pkt_end) pkt_count <= pkt_count + 16'd1;
    end
  end

endmodule
`default_nettype wire
